// File: rtl/cipher_round_ctrl.sv
// rtl/cipher_round_ctrl.sv - multi-round byte cipher sequencer with valid/ready handshakes
module cipher_round_ctrl #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       mode,
  input  logic [7:0] data_in,
  input  logic [7:0] key,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] data_out,
  output logic       busy,
  output logic [3:0] round_idx
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  state_t     state, state_nxt;
  logic [7:0] d_q, k_q;
  logic       m_q;
  logic [3:0] cnt_q;
  logic       last;
  logic [15:0] key_pair;
  logic [7:0] rkey, enc_x, d_round;

  assign last = (cnt_q == LAST);

  // Rotating the doubled key right and keeping the low byte gives ror by round_idx mod 8
  assign key_pair = {k_q, k_q} >> round_idx[2:0];
  assign rkey     = key_pair[7:0];
  assign enc_x    = d_q ^ rkey;
  assign d_round  = m_q ? ({d_q[6:0], d_q[7]} ^ rkey) : {enc_x[0], enc_x[7:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ROUND;
      ROUND:   if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == ROUND) || (state == DONE);
    round_idx = 4'd0;
    if (state == ROUND) begin
      round_idx = m_q ? (LAST - cnt_q) : cnt_q;
    end
  end

  // Working register doubles as data_out; it only moves on acceptance or in ROUND
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q   <= 8'h00;
      k_q   <= 8'h00;
      m_q   <= 1'b0;
      cnt_q <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_q   <= data_in;
            k_q   <= key;
            m_q   <= mode;
            cnt_q <= 4'd0;
          end
        end
        ROUND: begin
          d_q   <= d_round;
          cnt_q <= last ? 4'd0 : cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign data_out = d_q;

endmodule

// File: tb/tb_cipher_round_ctrl.sv
// tb/tb_cipher_round_ctrl.sv - scoreboard bench for cipher_round_ctrl over several ROUNDS values
`timescale 1ns/1ps
module tb_cipher_round_ctrl;

  localparam int NDUT = 5;

  typedef struct {
    logic [7:0] d;
    int         acc;
    int         r;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] key = 8'h00;
  logic       out_man = 1'b1;
  logic       stall_en = 1'b0;
  logic       rnd = 1'b1;
  logic       out_ready_eff;
  int         sel = 0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         pushes = 0;
  int         pops = 0;
  logic       prev_ov = 1'b0;
  exp_t       q[$];

  logic       ir   [NDUT];
  logic       ov   [NDUT];
  logic [7:0] dout [NDUT];
  logic       bz   [NDUT];
  logic [3:0] ridx [NDUT];

  logic       cur_ir, cur_ov, cur_bz;
  logic [7:0] cur_dout;
  logic [3:0] cur_ridx;

  assign out_ready_eff = stall_en ? rnd : out_man;
  assign cur_ir   = ir[sel];
  assign cur_ov   = ov[sel];
  assign cur_bz   = bz[sel];
  assign cur_dout = dout[sel];
  assign cur_ridx = ridx[sel];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1 rnd = 1'($urandom_range(0, 1));
  end

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    cipher_round_ctrl #(
      .ROUNDS(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 4 : g == 3 ? 9 : 15)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid && (sel == g)),
      .in_ready (ir[g]),
      .mode     (mode),
      .data_in  (data_in),
      .key      (key),
      .out_valid(ov[g]),
      .out_ready(out_ready_eff && (sel == g)),
      .data_out (dout[g]),
      .busy     (bz[g]),
      .round_idx(ridx[g])
    );
  end

  function automatic int rv(input int s);
    case (s)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 9;
      default: return 15;
    endcase
  endfunction

  function automatic logic [7:0] ror_n(input logic [7:0] x, input int n);
    logic [7:0] y = x;
    for (int i = 0; i < n % 8; i++) y = {y[0], y[7:1]};
    return y;
  endfunction

  function automatic logic [7:0] enc_model(input logic [7:0] x, input logic [7:0] k, input int r);
    logic [7:0] d = x;
    for (int i = 0; i < r; i++) begin
      d = d ^ ror_n(k, i);
      d = {d[0], d[7:1]};
    end
    return d;
  endfunction

  task automatic chk(input string nm, input int act, input int ex);
    total++;
    if (act != ex) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, ex, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input logic md, input logic [7:0] d,
                      input logic [7:0] k, input logic [7:0] e);
    int n = 0;
    exp_t x;
    sel = s; mode = md; data_in = d; key = k; in_valid = 1'b1;
    while (!cur_ir && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    x.d = e; x.acc = cyc + 1; x.r = rv(s);
    q.push_back(x);
    pushes++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cur_ov && !prev_ov) begin
        if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("latency", cyc - q[0].acc, q[0].r);
      end
      if (cur_ov && out_ready_eff) begin
        if (q.size() == 0) begin
          chk("spurious_output", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          pops++;
          chk("data_out", int'(cur_dout), int'(e.d));
        end
      end
      prev_ov = cur_ov;
    end else begin
      prev_ov = 1'b0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x, k, e;
    #12;
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_in_ready", int'(ir[i]), 1);
      chk("rst_out_valid", int'(ov[i]), 0);
      chk("rst_data_out", int'(dout[i]), 0);
      chk("rst_busy", int'(bz[i]), 0);
      chk("rst_round_idx", int'(ridx[i]), 0);
    end
    tick();
    rst = 1'b0;
    tick();

    // Abort mid-ROUND at ROUNDS=4; nothing is pushed for this byte
    sel = 2; out_man = 1'b1; data_in = 8'h77; key = 8'h12; mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_abort_busy", int'(cur_bz), 1);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", int'(cur_ir), 1);
    chk("abort_out_valid", int'(cur_ov), 0);
    chk("abort_data_out", int'(cur_dout), 0);
    chk("abort_busy", int'(cur_bz), 0);
    tick();
    rst = 1'b0;
    tick();
    send(2, 1'b0, 8'hA5, 8'h3C, 8'h5A);
    drain();

    // ROUNDS=1
    send(0, 1'b0, 8'h81, 8'h00, 8'hC0);
    send(0, 1'b1, 8'hC0, 8'h00, 8'h81);
    drain();

    // ROUNDS=2 with round_idx sequence
    send(1, 1'b0, 8'h01, 8'h01, 8'h40);
    chk("enc_ridx0", int'(cur_ridx), 0);
    tick();
    chk("enc_ridx1", int'(cur_ridx), 1);
    tick();
    chk("enc_ridx_done", int'(cur_ridx), 0);
    drain();
    send(1, 1'b1, 8'h40, 8'h01, 8'h01);
    chk("dec_ridx0", int'(cur_ridx), 1);
    tick();
    chk("dec_ridx1", int'(cur_ridx), 0);
    drain();

    // ROUNDS=4 default vector round trip
    send(2, 1'b1, 8'h5A, 8'h3C, 8'hA5);
    drain();

    // Backpressure and in-flight isolation
    out_man = 1'b0;
    send(2, 1'b0, 8'hA5, 8'h3C, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; data_in = 8'hFF; key = 8'h00; mode = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    begin
      int n = 0;
      while (!cur_ov && n < 20) begin
        tick();
        n++;
      end
      if (n >= 20) chk("done_timeout", 0, 1);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; data_in = 8'h11; key = 8'h22;
      chk("hold_out_valid", int'(cur_ov), 1);
      chk("hold_data_out", int'(cur_dout), 8'h5A);
      chk("hold_in_ready", int'(cur_ir), 0);
      chk("hold_busy", int'(cur_bz), 1);
      tick();
    end
    in_valid = 1'b0;
    out_man = 1'b1;
    drain();
    tick();
    chk("post_hs_in_ready", int'(cur_ir), 1);
    chk("post_hs_out_valid", int'(cur_ov), 0);

    // Random round trips with output stalls
    stall_en = 1'b1;
    for (int s = 0; s < NDUT; s++) begin
      if (s != 1) begin
        for (int j = 0; j < 250; j++) begin
          x = 8'($urandom);
          k = 8'($urandom);
          e = enc_model(x, k, rv(s));
          send(s, 1'b0, x, k, e);
          send(s, 1'b1, e, k, x);
        end
        drain();
      end
    end
    stall_en = 1'b0;
    drain();

    chk("queue_empty", q.size(), 0);
    chk("push_pop_count", pops, pushes);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cipher_round_ctrl.md
# cipher_round_ctrl

Multi-round sequencer for the 8-bit cryptosystem datapath. It accepts one byte plus key and mode over a valid/ready handshake, then applies one round per clock. An encrypt round is key XOR followed by a 1-bit circular right shift. A decrypt round is a 1-bit circular left shift followed by key XOR. Each round key is the base key rotated per round. It sits between the UART/byte front end and the output buffer and is the only block that drives the rotate datapath.

## Interface
- ROUNDS, default 4: number of rounds per byte. Legal range 1..15.
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request carries a byte to process.
- in_ready  output  1  block can accept a request (high only in IDLE).
- mode  input  1  0 = encrypt, 1 = decrypt; sampled on acceptance.
- data_in  input  8  plaintext (encrypt) or ciphertext (decrypt).
- key  input  8  base key; sampled on acceptance.
- out_valid  output  1  data_out holds a finished result.
- out_ready  input  1  consumer takes the result.
- data_out  output  8  result byte; meaningful only while out_valid is high.
- busy  output  1  high in ROUND and DONE.
- round_idx  output  4  round key index used at the next round edge (0 outside ROUND).

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, latch data_in, key and mode, then go to ROUND.
  - ROUND: one round per edge for ROUNDS edges, then go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Round key k_i = key rotated right by i bits (i mod 8), using the latched key.
- Encrypt, i = 0..ROUNDS-1 ascending: d <= ror1(d ^ k_i), where ror1(x) = {x[0], x[7:1]}.
- Decrypt, i = ROUNDS-1..0 descending: d <= rol1(d) ^ k_i, where rol1(x) = {x[6:0], x[7]}.
- Decrypt(encrypt(x, key), key) = x for every x, key and legal ROUNDS.
- Internal round counter counts 0..ROUNDS-1. round_idx = counter (encrypt) or ROUNDS-1-counter (decrypt).
- Inputs arriving while in_ready=0 are ignored; no queueing.
- Changes to key, mode or data_in after acceptance have no effect on the byte in flight.
- data_out is the working register. It must not change while out_valid=1.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, data_out=0x00, round_idx=0, counter 0.
- Reset asserted mid-ROUND or mid-DONE aborts immediately. The in-flight byte is discarded and no out_valid is produced for it.
- Acceptance edge E0 (in_valid & in_ready): in_ready drops after E0.
- Rounds occur on edges E1..E_ROUNDS.
- out_valid rises after E_ROUNDS: latency is ROUNDS cycles from acceptance to out_valid.
- out_valid and data_out hold until an edge with out_ready=1. After that edge: out_valid=0, in_ready=1.
- A new byte is accepted no earlier than the edge after the handshake. Peak throughput is one byte per ROUNDS+2 cycles with out_ready held high.
- out_ready is ignored outside DONE.
- ROUNDS=1: exactly one round edge, then DONE.
- round_idx wraps key rotation mod 8; ROUNDS above 8 reuses rotations.

## Test plan
- Reset behaviour: assert rst mid-ROUND at ROUNDS=4 -> outputs immediately show in_ready=1, out_valid=0, data_out=0x00. After release, the next accepted byte processes normally.
- Single-round encrypt then decrypt: ROUNDS=1, encrypt data 0x81, key 0x00 -> data_out 0xC0 one cycle after acceptance. Decrypt 0xC0, key 0x00 -> 0x81.
- Two-round key schedule: ROUNDS=2, encrypt data 0x01, key 0x01 -> 0x40. Decrypt 0x40, key 0x01 -> 0x01. round_idx sequence is 0,1 (encrypt) and 1,0 (decrypt).
- Default-rounds vector: ROUNDS=4, encrypt data 0xA5, key 0x3C -> 0x5A after exactly 4 cycles. Decrypt 0x5A -> 0xA5.
- Backpressure and in-flight isolation:
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid and data_out stable, in_ready=0, busy=1.
  - Pulse in_valid with new data during ROUND/DONE -> ignored.
  - Change key mid-ROUND -> result unchanged.
- Random round-trip: 1000 random data/key pairs with random out_ready stalls, ROUNDS in {1, 4, 9, 15} -> decrypt(encrypt(x)) = x. Latency is always ROUNDS, and no transaction is lost or duplicated.
